// File: rtl/serial_frame_controller.sv
// Serial frame sequencer: shifts in an address, checks it against MY_ADDR,
// captures the following payload into a one-entry valid/ready buffer.
module serial_frame_controller #(
    parameter int                ADDR_W  = 8,
    parameter logic [ADDR_W-1:0] MY_ADDR = 8'b00111111,
    parameter int                DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame,
    input  logic              sin_valid,
    input  logic              sin,
    output logic              selected,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              abort,
    output logic              overrun
);

    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, SKIP} state_t;

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] areg;
    logic [DATA_W-1:0] dreg;
    logic [ADDR_W-1:0] a_next;
    logic [DATA_W-1:0] d_next;
    logic              take;

    always_comb begin
        take   = frame & sin_valid;
        a_next = {areg[ADDR_W-2:0], sin};
        d_next = {dreg[DATA_W-2:0], sin};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            areg     <= '0;
            dreg     <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            selected <= 1'b0;
            abort    <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            abort   <= 1'b0;
            overrun <= 1'b0;
            // Consumer drain; a payload loading this same cycle overrides it below.
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (take) begin
                        areg  <= a_next;
                        count <= CNT_W'(1);
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (!frame) begin
                        abort    <= 1'b1;
                        selected <= 1'b0;
                        count    <= '0;
                        state    <= IDLE;
                    end else if (take) begin
                        areg <= a_next;
                        if (count == CNT_W'(ADDR_W - 1)) begin
                            count <= '0;
                            if (a_next == MY_ADDR) begin
                                selected <= 1'b1;
                                state    <= DATA;
                            end else begin
                                state <= SKIP;
                            end
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (!frame) begin
                        abort    <= 1'b1;
                        selected <= 1'b0;
                        count    <= '0;
                        state    <= IDLE;
                    end else if (take) begin
                        dreg <= d_next;
                        if (count == CNT_W'(DATA_W - 1)) begin
                            count <= '0;
                            state <= SKIP;
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= d_next;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                SKIP: begin
                    if (!frame) begin
                        selected <= 1'b0;
                        count    <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_controller.sv
// Bench for serial_frame_controller: directed scenarios plus random frames,
// every cycle compared against a bit-count based reference model.
module tb_serial_frame_controller;

    localparam int         ADDR_W = 8;
    localparam int         DATA_W = 8;
    localparam logic [7:0] MY     = 8'h3F;

    logic       clk = 1'b0;
    logic       rst, frame, sin_valid, sin, rx_ready;
    logic       selected, rx_valid, abort, overrun;
    logic [7:0] rx_data;

    serial_frame_controller #(.ADDR_W(ADDR_W), .MY_ADDR(MY), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .frame(frame), .sin_valid(sin_valid), .sin(sin),
        .selected(selected), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .abort(abort), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: tracks how many bits the current frame has taken.
    int         m_n;
    logic [7:0] m_addr, m_data, m_rxd;
    logic       m_sel, m_rxv, m_abort, m_ovr;

    int         abort_cnt, ovr_cnt, sel_cnt;
    logic [7:0] last_rx;
    bit         rand_rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task model_step;
        if (rst) begin
            m_n = 0; m_addr = '0; m_data = '0; m_rxd = '0;
            m_sel = 0; m_rxv = 0; m_abort = 0; m_ovr = 0;
        end else begin
            m_abort = 0;
            m_ovr   = 0;
            if (m_rxv && rx_ready) m_rxv = 0;
            if (!frame) begin
                if ((m_n > 0 && m_n < ADDR_W) || (m_sel && m_n < ADDR_W + DATA_W))
                    m_abort = 1;
                m_n   = 0;
                m_sel = 0;
            end else if (sin_valid) begin
                if (m_n < 1000) m_n++;
                if (m_n <= ADDR_W) begin
                    m_addr = 8'(m_addr * 2 + 8'(sin));
                    if (m_n == ADDR_W) m_sel = (m_addr == MY);
                end else if (m_sel && m_n <= ADDR_W + DATA_W) begin
                    m_data = 8'(m_data * 2 + 8'(sin));
                    if (m_n == ADDR_W + DATA_W) begin
                        if (m_rxv) m_ovr = 1;
                        else begin
                            m_rxd = m_data;
                            m_rxv = 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic cyc(input logic f, input logic v, input logic s, input logic r);
        frame = f; sin_valid = v; sin = s; rst = r;
        if (rand_rdy) rx_ready = 1'($urandom);
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("selected", 32'(selected), 32'(m_sel));
        chk("rx_valid", 32'(rx_valid), 32'(m_rxv));
        chk("rx_data",  32'(rx_data),  32'(m_rxd));
        chk("abort",    32'(abort),    32'(m_abort));
        chk("overrun",  32'(overrun),  32'(m_ovr));
        if (abort)    abort_cnt++;
        if (overrun)  ovr_cnt++;
        if (selected) sel_cnt++;
        if (rx_valid) last_rx = rx_data;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input int nbits,
                              input int gap, input int extra, input bit rdy_last, input bit drop);
        logic [15:0] bits;
        bits = {a, d};
        for (int i = 0; i < nbits; i++) begin
            for (int g = 0; g < gap - 1; g++) cyc(1, 0, ~bits[15-i], 0);
            if (rdy_last) rx_ready = (i == nbits - 1);
            cyc(1, 1, bits[15-i], 0);
            if (rdy_last) rx_ready = 0;
        end
        for (int e = 0; e < extra; e++) cyc(1, 1, 1'($urandom), 0);
        if (drop) cyc(0, 0, 0, 0);
    endtask

    task clr_cnt;
        abort_cnt = 0; ovr_cnt = 0; sel_cnt = 0; last_rx = 8'h00;
    endtask

    initial begin
        rand_rdy = 0;
        rx_ready = 0;
        clr_cnt();
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("reset_selected", 32'(selected), 32'd0);
        chk("reset_rx_valid", 32'(rx_valid), 32'd0);
        chk("reset_rx_data",  32'(rx_data),  32'd0);
        cyc(0, 0, 0, 0);

        // Matching frame, consumer ready
        rx_ready = 1; clr_cnt();
        send_frame(MY, 8'hA5, 16, 1, 0, 0, 1);
        chk("match_data", 32'(last_rx), 32'hA5);
        chk("match_sel_cycles", 32'(sel_cnt), 32'd9);
        chk("match_sel_end", 32'(selected), 32'd0);

        // Mismatched address, then a matching frame
        clr_cnt();
        send_frame(8'h3E, 8'hFF, 16, 1, 2, 0, 1);
        chk("mismatch_sel", 32'(sel_cnt), 32'd0);
        chk("mismatch_abort", 32'(abort_cnt), 32'd0);
        send_frame(MY, 8'h5A, 16, 1, 0, 0, 1);
        chk("after_mismatch_data", 32'(last_rx), 32'h5A);

        // Gapped bits
        clr_cnt();
        send_frame(MY, 8'hA5, 16, 3, 0, 0, 1);
        chk("gap_data", 32'(last_rx), 32'hA5);

        // Abort after address plus 3 payload bits
        clr_cnt();
        send_frame(MY, 8'h0F, 11, 1, 0, 0, 1);
        chk("abort_count", 32'(abort_cnt), 32'd1);
        chk("abort_rx_valid", 32'(rx_valid), 32'd0);
        send_frame(MY, 8'h0F, 16, 1, 0, 0, 1);
        chk("after_abort_data", 32'(last_rx), 32'h0F);

        // Backpressure and overrun
        rx_ready = 0; clr_cnt();
        send_frame(MY, 8'h11, 16, 1, 0, 0, 1);
        send_frame(MY, 8'h22, 16, 1, 0, 0, 1);
        chk("bp_overrun", 32'(ovr_cnt), 32'd1);
        chk("bp_held", 32'(rx_data), 32'h11);
        send_frame(MY, 8'h33, 16, 1, 0, 1, 1);
        chk("bp_swap_data", 32'(rx_data), 32'h33);
        chk("bp_swap_valid", 32'(rx_valid), 32'd1);
        chk("bp_swap_overrun", 32'(ovr_cnt), 32'd1);
        rx_ready = 1;
        cyc(0, 0, 0, 0);

        // Reset mid-payload with a pending rx_valid
        rx_ready = 0; clr_cnt();
        send_frame(MY, 8'h77, 16, 1, 0, 0, 1);
        send_frame(MY, 8'h55, 12, 1, 0, 0, 0);
        cyc(1, 0, 0, 1);
        chk("midrst_valid", 32'(rx_valid), 32'd0);
        chk("midrst_data", 32'(rx_data), 32'd0);
        chk("midrst_sel", 32'(selected), 32'd0);
        cyc(0, 0, 0, 0);
        rx_ready = 1; clr_cnt();
        send_frame(MY, 8'hC3, 16, 1, 0, 0, 1);
        chk("postrst_data", 32'(last_rx), 32'hC3);

        // Random frames with random consumer readiness
        rand_rdy = 1;
        for (int k = 0; k < 40; k++) begin
            logic [7:0] a, d;
            int nb, ex;
            a  = 1'($urandom) ? MY : 8'($urandom);
            d  = 8'($urandom);
            nb = ($urandom % 4 == 0) ? int'($urandom_range(1, 15)) : 16;
            ex = (nb == 16) ? int'($urandom_range(0, 3)) : 0;
            send_frame(a, d, nb, int'($urandom_range(1, 3)), ex, 0, 1);
            if (1'($urandom)) cyc(0, 0, 0, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serial_frame_controller.md
# serial_frame_controller

Sequences one serial frame on the team's single-wire address bus: collects a serial address, decides whether this node is selected, then captures the following payload into a one-entry output buffer with a valid/ready handshake. It sits between the serial line front end (which supplies bit strobes and a frame envelope) and the node's parallel consumer logic. It also owns frame abort and overrun reporting, so downstream logic only ever sees complete, addressed payloads.

## Interface
- ADDR_W, 8, address field width in bits, MSB first
- MY_ADDR, 8'b00111111, node address; width ADDR_W
- DATA_W, 8, payload width in bits, MSB first
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- frame  in  1  frame envelope; high for the whole frame, low for at least 1 cycle between frames
- sin_valid  in  1  qualifies sin for this cycle; bits may have arbitrary gaps
- sin  in  1  serial bit
- selected  out  1  address matched; high until frame end
- rx_data  out  DATA_W  captured payload, held while rx_valid
- rx_valid  out  1  payload available
- rx_ready  in  1  consumer accepts rx_data
- abort  out  1  1-cycle pulse: frame dropped before payload complete
- overrun  out  1  1-cycle pulse: payload completed while buffer full and not draining; payload discarded

## Operation
- States: IDLE, ADDR, DATA, SKIP.
- A bit is taken only when frame=1 and sin_valid=1 in the same cycle. Shift is MSB first: sreg <= {sreg, sin}.
- Bit counter width is $clog2(max(ADDR_W, DATA_W)+1). It is cleared on every state entry.
- IDLE: on a taken bit, shift it into the address register, set count=1, and go to ADDR. With frame=1 and no bit taken, stay in IDLE.
- ADDR: shift each taken bit. When the ADDR_W-th bit is taken, compare the full ADDR_W-bit value (including that bit) against MY_ADDR.
  - Match: go to DATA and set selected<=1.
  - Mismatch: go to SKIP.
- DATA: shift each taken bit. When the DATA_W-th bit is taken, go to SKIP (selected stays 1) and resolve the buffer:
  - If rx_valid=0, or rx_valid=1 with rx_ready=1 this cycle: load rx_data and set rx_valid<=1.
  - Otherwise (rx_valid=1, rx_ready=0): rx_data is unchanged, pulse overrun, and the new payload is dropped.
- SKIP: ignore all bits while frame=1. When frame=0, go to IDLE and clear selected.
- Abort: if frame=0 in ADDR or DATA, pulse abort, go to IDLE, and clear selected. Any partial payload is discarded and rx_data/rx_valid are untouched. A sin_valid in that cycle is ignored.
- IDLE with frame=0: stay in IDLE. No abort is raised for an empty frame.
- Output handshake, independent of the FSM:
  - rx_valid & rx_ready at an edge clears rx_valid, unless a new payload loads in the same cycle, in which case rx_valid stays 1 with the new data.
  - rx_data does not change while rx_valid=1 except on that simultaneous load.

## Timing
- Reset (rst=1 at edge): state=IDLE, counters=0, shift registers=0, rx_data=0, rx_valid=0, selected=0, abort=0, overrun=0. Reset overrides every other action, including mid-DATA and a pending rx_valid.
- selected rises at the edge that takes the ADDR_W-th address bit and is visible the following cycle.
- selected falls at the edge where frame=0 is sampled in SKIP or DATA.
- rx_valid rises at the edge that takes the DATA_W-th payload bit, i.e. latency 1 cycle after the last bit.
- abort and overrun are high for exactly one cycle, asserted by the same edge that detects the condition.
- Minimum frame is ADDR_W+DATA_W taken bits. Extra bits in SKIP have no effect.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Match, ready (MY_ADDR default): frame=1, sin_valid=1 continuously, bits 0x3F then 0xA5, rx_ready=1 → selected=1 from the cycle after bit 8; rx_valid=1 for exactly 1 cycle with rx_data=0xA5 the cycle after bit 16; selected=0 the cycle after frame drops.
- Mismatch: address 0x3E, payload 0xFF → selected, rx_valid, abort, and overrun all stay 0 throughout; the next frame with 0x3F/0x5A yields rx_data=0x5A.
- Gapped bits: same frame as the match test with sin_valid high only every third cycle, and sin toggled on invalid cycles → identical outputs; rx_valid follows the 16th valid bit by 1 cycle.
- Abort: frame drops after address 0x3F plus 3 payload bits → abort pulses once, selected=0 next cycle, rx_valid stays 0; a following full frame with payload 0x0F delivers rx_data=0x0F.
- Backpressure: rx_ready=0; frames with payloads 0x11 then 0x22 → rx_data=0x11 held, overrun pulses once at the 0x22 completion. Then a third frame (0x33) completes in the same cycle rx_ready=1 → rx_data=0x33, rx_valid stays 1, no overrun.
- Reset mid-DATA with rx_valid=1 pending → next cycle all outputs are 0 and state is IDLE; the next matching frame with payload 0xC3 delivers rx_data=0xC3 normally.
